// File: rtl/wavelet_pkg.sv
// Shared types and constants for the wavelet obuff egress path.
package wavelet_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } obuff_rd_state_t;

  // obuff read data returns this many cycles after the read enable.
  localparam int unsigned OBUFF_RD_LATENCY = 1;

  // Skid buffer depth; also the read credit limit (outstanding + buffered).
  localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/obuff_reader_if.sv
// obuff read port plus the valid/ready egress stream, seen from the reader.
interface obuff_reader_if #(
  parameter int unsigned INPUT_WIDTH      = 32,
  parameter int unsigned OBUFF_ADDR_WIDTH = 12
);

  logic                        obuff_r_en;
  logic [OBUFF_ADDR_WIDTH-1:0] obuff_r_addr;
  logic [INPUT_WIDTH-1:0]      obuff_r_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [INPUT_WIDTH-1:0]      out_data;
  logic                        out_last;

  modport master (
    output obuff_r_en, obuff_r_addr, out_valid, out_data, out_last,
    input  obuff_r_data, out_ready
  );

  modport slave (
    input  obuff_r_en, obuff_r_addr, out_valid, out_data, out_last,
    output obuff_r_data, out_ready
  );

endinterface

// File: rtl/obuff_skid_fifo.sv
// Two-entry synchronous FIFO holding returned obuff words until accepted downstream.
module obuff_skid_fifo #(
  parameter int unsigned INPUT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [INPUT_WIDTH-1:0] din,
  input  logic                   pop,
  output logic [INPUT_WIDTH-1:0] dout,
  output logic                   full,
  output logic                   empty,
  output logic [1:0]             count
);

  logic [INPUT_WIDTH-1:0] mem_q [2];
  logic                   wr_ptr_q;
  logic                   rd_ptr_q;
  logic [1:0]             count_q;
  logic                   push_c;
  logic                   pop_c;

  // A pop frees a slot in the same cycle, so push into a full FIFO is fine if it also pops.
  assign pop_c  = pop & (count_q != 2'd0);
  assign push_c = push & ((count_q != 2'd2) | pop_c);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_c) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push_c) - 2'(pop_c);
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;

endmodule

// File: rtl/obuff_reader.sv
// Drains a contiguous (wrapping) obuff region onto a valid/ready stream with a last marker.
module obuff_reader
  import wavelet_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH      = 32,
  parameter int unsigned OBUFF_CELL_COUNT = 4096,
  parameter int unsigned OBUFF_ADDR_WIDTH = $clog2(OBUFF_CELL_COUNT),
  parameter int unsigned LEN_WIDTH        = OBUFF_ADDR_WIDTH + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [OBUFF_ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]        length,
  output logic                        busy,
  output logic                        done,
  obuff_reader_if.master              bus
);

  obuff_rd_state_t             state_q;
  obuff_rd_state_t             state_d;
  logic                        busy_d;
  logic                        done_d;
  logic [OBUFF_ADDR_WIDTH-1:0] rd_addr_q;
  logic [LEN_WIDTH-1:0]        rd_left_q;
  logic [LEN_WIDTH-1:0]        out_left_q;
  logic                        inflight_q;
  logic                        accept_c;
  logic                        issue_c;
  logic                        pop_c;
  logic [2:0]                  credit_use_c;
  logic [INPUT_WIDTH-1:0]      fifo_dout;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [1:0]                  fifo_count;

  // A non-empty transfer is accepted only from IDLE; zero length goes straight to DONE.
  assign accept_c = (state_q == IDLE) & start & (length != '0);
  assign pop_c    = bus.out_valid & bus.out_ready;

  // Slots committed after this cycle: buffered words minus the one leaving, plus the one in flight.
  assign credit_use_c = 3'(fifo_count) + 3'(inflight_q) - 3'(pop_c);
  assign issue_c      = (state_q == READ) & (rd_left_q != '0) & (credit_use_c < 3'(SKID_DEPTH));

  // State register with registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (length != '0) ? READ : DONE;
      READ:    if (rd_left_q == '0) state_d = DRAIN;
      DRAIN:   if (out_left_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the upcoming state so they line up with it.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    if ((state_d == READ) || (state_d == DRAIN)) busy_d = 1'b1;
    if (state_d == DONE) done_d = 1'b1;
  end

  // Read address / remaining-count bookkeeping and the one-cycle read-return flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr_q  <= '0;
      rd_left_q  <= '0;
      out_left_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue_c;
      if (accept_c) begin
        rd_addr_q  <= base_addr;
        rd_left_q  <= length;
        out_left_q <= length;
      end else begin
        if (issue_c) begin
          rd_addr_q <= rd_addr_q + OBUFF_ADDR_WIDTH'(1);
          rd_left_q <= rd_left_q - LEN_WIDTH'(1);
        end
        if (pop_c) begin
          out_left_q <= out_left_q - LEN_WIDTH'(1);
        end
      end
    end
  end

  obuff_skid_fifo #(
    .INPUT_WIDTH (INPUT_WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (bus.obuff_r_data),
    .pop   (pop_c),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.obuff_r_en   = issue_c;
  assign bus.obuff_r_addr = rd_addr_q;
  assign bus.out_valid    = ~fifo_empty;
  assign bus.out_data     = fifo_dout;
  assign bus.out_last     = ~fifo_empty & (out_left_q == LEN_WIDTH'(1));

  // The read credit must never let a returning word arrive at a full skid buffer.
  skid_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(fifo_full && inflight_q && !pop_c));

endmodule

// File: tb/tb_obuff_reader.sv
// Directed bench for obuff_reader with a queue-based scoreboard checked every cycle.
module tb_obuff_reader;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 12;
  localparam int unsigned LW    = 13;
  localparam int unsigned CELLS = 4096;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] length;
  logic          busy;
  logic          done;

  obuff_reader_if #(.INPUT_WIDTH(DW), .OBUFF_ADDR_WIDTH(AW)) bus ();

  obuff_reader #(
    .INPUT_WIDTH      (DW),
    .OBUFF_CELL_COUNT (CELLS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // obuff register file: registered read, data one cycle after the enable.
  logic [DW-1:0] mem [CELLS];
  always @(posedge clk) begin
    if (bus.obuff_r_en) bus.obuff_r_data <= mem[bus.obuff_r_addr];
  end

  int vectors     = 0;
  int miscompares = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Each obuff cell holds its own address plus 100.
  function automatic logic [31:0] word_at(input logic [AW-1:0] a);
    return 32'(a) + 32'd100;
  endfunction

  // Scoreboard state.
  logic [31:0]   exp_q  [$];
  logic [AW-1:0] addr_q [$];
  logic [AW-1:0] rd_log [$];
  int            n_edge = 0;
  int            done_at = -1;
  bit            active = 0;
  bit            busy_m = 0;
  bit            prev_stall = 0;
  logic [31:0]   prev_data = '0;
  logic          prev_last = 1'b0;
  int            outstanding = 0;
  int            ren_total = 0;
  int            xfer_hs = 0;
  int            xfer_first_n = 0;
  int            xfer_last_n = 0;
  bit            done_seen = 0;
  logic [31:0]   last_hs_data = '0;
  logic          last_hs_last = 1'b0;

  // Compare process: checks every DUT output against the scoreboard each cycle.
  always @(negedge clk) begin : cmp
    bit exp_done;
    bit hs;
    if (!rst) begin
      exp_q.delete();
      addr_q.delete();
      active      = 0;
      busy_m      = 0;
      done_at     = -1;
      outstanding = 0;
      prev_stall  = 0;
    end else begin
      n_edge++;
      exp_done = (done_at == n_edge);
      if (exp_done) busy_m = 0;
      check("busy", 32'(busy), 32'(busy_m));
      check("done", 32'(done), 32'(exp_done));
      if (done) done_seen = 1;

      if (prev_stall) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_data", bus.out_data, prev_data);
        check("stall_last", 32'(bus.out_last), 32'(prev_last));
      end
      check("out_last", 32'(bus.out_last), 32'(bus.out_valid && (exp_q.size() == 1)));

      if (bus.obuff_r_en) begin
        ren_total++;
        check("read_expected", 32'(addr_q.size() != 0), 32'd1);
        if (addr_q.size() != 0) check("read_addr", 32'(bus.obuff_r_addr), 32'(addr_q.pop_front()));
        rd_log.push_back(bus.obuff_r_addr);
        outstanding++;
      end

      hs = bus.out_valid && bus.out_ready;
      if (hs) begin
        check("hs_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("out_data", bus.out_data, exp_q.pop_front());
        if (xfer_hs == 0) xfer_first_n = n_edge;
        xfer_last_n  = n_edge;
        xfer_hs++;
        outstanding--;
        last_hs_data = bus.out_data;
        last_hs_last = bus.out_last;
        if (exp_q.size() == 0) done_at = n_edge + 2;
      end
      check("outstanding", 32'(outstanding <= 2), 32'd1);

      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;

      if (start && !active) begin
        active  = 1;
        xfer_hs = 0;
        if (length == '0) begin
          done_at = n_edge + 1;
        end else begin
          for (int k = 0; k < int'(length); k++) begin
            exp_q.push_back(word_at(AW'(32'(base_addr) + 32'(k))));
            addr_q.push_back(AW'(32'(base_addr) + 32'(k)));
          end
          busy_m = 1;
        end
      end
      if (exp_done) active = 0;
    end
  end

  logic [15:0] ready_pat = 16'b1001_1010_0110_0011;

  task automatic pulse_start(input logic [AW-1:0] b, input logic [LW-1:0] len);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = b;
    length    = len;
    done_seen = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit bp);
    int i;
    i = 0;
    while (!done_seen && i < bound) begin
      @(posedge clk); #1;
      if (bp) bus.out_ready = ready_pat[i % 16];
      i++;
    end
    bus.out_ready = 1'b1;
    check("done_timeout", 32'(done_seen), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_ren"},   32'(bus.obuff_r_en), 32'd0);
    check({tag, "_raddr"}, 32'(bus.obuff_r_addr), 32'd0);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_last"},  32'(bus.out_last), 32'd0);
    check({tag, "_data"},  bus.out_data, 32'd0);
  endtask

  initial begin
    int ren_before;
    int i;
    for (int a = 0; a < int'(CELLS); a++) mem[a] = 32'(a) + 32'd100;
    rst           = 1'b0;
    start         = 1'b0;
    base_addr     = '0;
    length        = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Basic drain with start-up latency pinned by hand.
    pulse_start(AW'(129), LW'(129));
    @(negedge clk);
    check("lat_ren", 32'(bus.obuff_r_en), 32'd1);
    check("lat_raddr", 32'(bus.obuff_r_addr), 32'd129);
    @(negedge clk);
    check("lat_valid0", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_valid1", 32'(bus.out_valid), 32'd1);
    check("lat_data", bus.out_data, 32'd229);
    wait_done(300, 0);
    check("basic_count", 32'(xfer_hs), 32'd129);
    check("basic_span", 32'(xfer_last_n - xfer_first_n), 32'd128);
    check("basic_last_data", last_hs_data, 32'd357);
    check("basic_last_flag", 32'(last_hs_last), 32'd1);

    // Address wrap-around.
    rd_log.delete();
    pulse_start(AW'(4094), LW'(4));
    wait_done(50, 0);
    check("wrap_nreads", 32'(rd_log.size()), 32'd4);
    if (rd_log.size() == 4) begin
      check("wrap_a0", 32'(rd_log[0]), 32'd4094);
      check("wrap_a1", 32'(rd_log[1]), 32'd4095);
      check("wrap_a2", 32'(rd_log[2]), 32'd0);
      check("wrap_a3", 32'(rd_log[3]), 32'd1);
    end
    check("wrap_last_data", last_hs_data, 32'd101);

    // Back-pressure with a fixed ready pattern.
    pulse_start(AW'(1000), LW'(8));
    wait_done(200, 1);
    check("bp_count", 32'(xfer_hs), 32'd8);
    check("bp_last_data", last_hs_data, 32'd1107);

    // Zero length: done without reads.
    ren_before = ren_total;
    pulse_start(AW'(77), LW'(0));
    wait_done(10, 0);
    check("zero_reads", 32'(ren_total - ren_before), 32'd0);

    // Restart pulse while busy is ignored.
    pulse_start(AW'(10), LW'(6));
    pulse_start(AW'(500), LW'(3));
    wait_done(50, 0);
    check("restart_count", 32'(xfer_hs), 32'd6);
    check("restart_last_data", last_hs_data, 32'd115);

    // Asynchronous reset after three words of ten.
    pulse_start(AW'(200), LW'(10));
    i = 0;
    while (xfer_hs < 3 && i < 50) begin
      @(posedge clk);
      i++;
    end
    check("rst_wait", 32'(xfer_hs), 32'd3);
    #2 rst = 1'b0;
    #1 check_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    check("midrst_no_done", 32'(done_seen), 32'd0);
    pulse_start(AW'(0), LW'(2));
    wait_done(50, 0);
    check("post_count", 32'(xfer_hs), 32'd2);
    check("post_last_data", last_hs_data, 32'd101);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
